fifo_rr_scheduler: RTL and testbench



---
 rtl/fifo_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of NUM_REQ source FIFOs into one valid/ready channel,
// with a per-grant burst limit, a channel enable mask and a source tag.
module fifo_rr_scheduler #(
    parameter type T = logic [31:0],
    parameter int NUM_REQ = 4,
    parameter int BURST = 4,
    localparam int SRC_W = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] fifo_empty_i,
    input  T                   fifo_rdata_i [NUM_REQ],
    output logic [NUM_REQ-1:0] fifo_rd_en_o,
    input  logic [NUM_REQ-1:0] mask_i,
    output T                   out_data_o,
    output logic [SRC_W-1:0]   out_src_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] elig;
    logic               space;
    logic               cont;
    logic               found;
    logic               pop;
    logic [SRC_W-1:0]   idx;
    logic [SRC_W-1:0]   scan_sel;
    logic [SRC_W-1:0]   sel;

    // Eligibility, burst continuation and rotating first-eligible search from cur+1.
    always_comb begin
        elig     = ~fifo_empty_i & mask_i;
        space    = !out_valid_o || out_ready_i;
        cont     = (state_q == ACTIVE) && elig[cur_q] && (cnt_q < CNT_W'(BURST));
        scan_sel = cur_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = SRC_W'((int'(cur_q) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                scan_sel = idx;
                found    = 1'b1;
            end
        end
        sel = cont ? cur_q : scan_sel;
        pop = space && (|elig) && !reset_i;
    end

    // One-hot read strobe to the granted FIFO; silent in reset or when stalled.
    always_comb begin
        fifo_rd_en_o = '0;
        if (pop) begin
            fifo_rd_en_o[sel] = 1'b1;
        end
    end

    // Next owner / burst count; backpressure holds the burst rather than breaking it.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ACTIVE;
                    cur_d   = sel;
                    cnt_d   = CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (pop) begin
                    if (cont) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cur_d = sel;
                        cnt_d = CNT_W'(1);
                    end
                end else if (!(|elig)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler state; cur resets to the last index so the first search starts at 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cur_q   <= SRC_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register: load on pop, drop valid once accepted with nothing new.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_src_o   <= '0;
        end else if (pop) begin
            out_valid_o <= 1'b1;
            out_data_o  <= fifo_rdata_i[sel];
            out_src_o   <= sel;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    assign busy_o = (state_q == ACTIVE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: behavioural source FIFOs,
// hand-computed output streams, burst, mask, backpressure and reset cases.
module tb_fifo_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [3:0]  empty;
    logic [3:0]  mask;
    logic [31:0] rdata [4];
    bit          use2;

    logic [3:0]  rd_en1, rd_en2, rd_en;
    logic [31:0] data1, data2, o_data;
    logic [1:0]  src1, src2, o_src;
    logic        v1, v2, o_valid;
    logic        b1, b2, o_busy;
    int          o_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [4][16];
    int          hd [4];
    int          tl [4];

    fifo_rr_scheduler #(.NUM_REQ(4), .BURST(4)) dut (
        .clk_i(clk), .reset_i(reset), .fifo_empty_i(empty),
        .fifo_rdata_i(rdata), .fifo_rd_en_o(rd_en1), .mask_i(mask),
        .out_data_o(data1), .out_src_o(src1), .out_valid_o(v1),
        .out_ready_i(ready), .busy_o(b1)
    );

    fifo_rr_scheduler #(.NUM_REQ(4), .BURST(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .fifo_empty_i(empty),
        .fifo_rdata_i(rdata), .fifo_rd_en_o(rd_en2), .mask_i(mask),
        .out_data_o(data2), .out_src_o(src2), .out_valid_o(v2),
        .out_ready_i(ready), .busy_o(b2)
    );

    assign rd_en   = use2 ? rd_en2 : rd_en1;
    assign o_data  = use2 ? data2 : data1;
    assign o_src   = use2 ? src2 : src1;
    assign o_valid = use2 ? v2 : v1;
    assign o_busy  = use2 ? b2 : b1;
    assign o_cnt   = use2 ? int'(dut2.cnt_q) : int'(dut.cnt_q);

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source FIFO models: pop on the active DUT's rd_en, refresh head/empty.
    always @(posedge clk) begin
        chk("rden_legal1", 32'(rd_en1 & (empty | ~mask)), 32'd0);
        chk("rden_legal2", 32'(rd_en2 & (empty | ~mask)), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i] && hd[i] < tl[i]) hd[i]++;
            empty[i] <= (hd[i] == tl[i]);
            rdata[i] <= mem[i][hd[i]];
        end
    end

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
    endtask

    task automatic load(input int ch, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][tl[ch]] = base + 32'(k);
            tl[ch]++;
        end
    endtask

    // One reset cycle; returns just after release, before the first pop edge.
    task automatic do_reset(input bit u2);
        use2  = u2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    int pat [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
    int c0, c2;
    logic [31:0] exp_d;

    initial begin
        reset = 1'b1;
        ready = 1'b1;
        mask  = 4'hF;
        empty = 4'hF;
        use2  = 1'b0;
        for (int i = 0; i < 4; i++) rdata[i] = '0;
        clear_q();
        @(negedge clk);
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_data", data1, 32'd0);
        chk("rst_src", 32'(src1), 32'd0);
        chk("rst_busy", 32'(b1), 32'd0);
        chk("rst_rden", 32'(rd_en1), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);

        // single channel
        clear_q();
        load(1, 32'hA1, 3);
        do_reset(0);
        chk("single_rden0", 32'(rd_en), 32'h2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("single_valid", 32'(o_valid), 32'd1);
            chk("single_src", 32'(o_src), 32'd1);
            chk("single_data", o_data, 32'hA1 + 32'(k));
            chk("single_rden", 32'(rd_en), (k < 2) ? 32'h2 : 32'h0);
        end
        @(negedge clk);
        chk("single_vdrop", 32'(o_valid), 32'd0);
        chk("single_idle", 32'(o_busy), 32'd0);

        // burst rotation between ch0 and ch2
        clear_q();
        load(0, 32'h100, 6);
        load(2, 32'h200, 6);
        do_reset(0);
        c0 = 0;
        c2 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pat[k] == 0) begin
                exp_d = 32'h100 + 32'(c0);
                c0++;
            end else begin
                exp_d = 32'h200 + 32'(c2);
                c2++;
            end
            chk("rot_valid", 32'(o_valid), 32'd1);
            chk("rot_src", 32'(o_src), 32'(pat[k]));
            chk("rot_data", o_data, exp_d);
        end
        @(negedge clk);
        chk("rot_end", 32'(o_valid), 32'd0);

        // lone channel at limit, BURST=2 instance
        clear_q();
        load(3, 32'h300, 5);
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lone_valid", 32'(o_valid), 32'd1);
            chk("lone_src", 32'(o_src), 32'd3);
            chk("lone_data", o_data, 32'h300 + 32'(k));
            chk("lone_cnt", 32'(o_cnt), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(negedge clk);
        chk("lone_end", 32'(o_valid), 32'd0);

        // backpressure
        clear_q();
        load(0, 32'h400, 4);
        do_reset(0);
        chk("bp_rden0", 32'(rd_en), 32'h1);
        @(negedge clk);
        chk("bp_first", o_data, 32'h400);
        ready = 1'b0;
        #1;
        chk("bp_stall_rden", 32'(rd_en), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("bp_hold_data", o_data, 32'h400);
            chk("bp_hold_valid", 32'(o_valid), 32'd1);
            chk("bp_hold_rden", 32'(rd_en), 32'h0);
            chk("bp_hold_cnt", 32'(o_cnt), 32'd1);
        end
        ready = 1'b1;
        #1;
        chk("bp_resume_rden", 32'(rd_en), 32'h1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("bp_data", o_data, 32'h400 + 32'(k));
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_cnt", 32'(o_cnt), 32'(k + 1));
        end
        @(negedge clk);
        chk("bp_end", 32'(o_valid), 32'd0);

        // mask
        clear_q();
        load(0, 32'h500, 3);
        load(1, 32'h510, 4);
        mask = 4'b0010;
        do_reset(0);
        chk("mask_rden0", 32'(rd_en), 32'h2);
        @(negedge clk);
        chk("mask_src1", 32'(o_src), 32'd1);
        chk("mask_data1", o_data, 32'h510);
        @(negedge clk);
        chk("mask_data2", o_data, 32'h511);
        chk("mask_cnt2", 32'(o_cnt), 32'd2);
        mask = 4'b0001;
        #1;
        chk("mask_switch_rden", 32'(rd_en), 32'h1);
        @(negedge clk);
        chk("mask_src0", 32'(o_src), 32'd0);
        chk("mask_data0", o_data, 32'h500);
        chk("mask_cnt_restart", 32'(o_cnt), 32'd1);

        // reset mid-burst
        clear_q();
        load(0, 32'h600, 1);
        load(2, 32'h620, 4);
        mask = 4'b1110;
        do_reset(0);
        @(negedge clk);
        chk("mrst_src2", 32'(o_src), 32'd2);
        chk("mrst_data", o_data, 32'h620);
        @(negedge clk);
        chk("mrst_cnt2", 32'(o_cnt), 32'd2);
        chk("mrst_valid", 32'(o_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_rden_in_rst", 32'(rd_en), 32'h0);
        @(negedge clk);
        chk("mrst_vclr", 32'(o_valid), 32'd0);
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_cnt0", 32'(o_cnt), 32'd0);
        chk("mrst_rden", 32'(rd_en), 32'h0);
        reset = 1'b0;
        mask = 4'hF;
        #1;
        chk("mrst_lowest_rden", 32'(rd_en), 32'h1);
        @(negedge clk);
        chk("mrst_lowest_src", 32'(o_src), 32'd0);
        chk("mrst_lowest_data", o_data, 32'h600);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
